// File: rtl/paint_pkg.sv
// Shared types and helpers for the frame-SRAM arbiter: pixel-write entry, arbiter state, word addressing.
// Two pixels per 16-bit word: even x in [15:8], odd x in [7:0].
package paint_pkg;

    localparam int H_RES = 640;
    localparam int V_RES = 480;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] c;
    } pix_wr_t;

    typedef enum logic [1:0] {
        IDLE,
        DISP_RD,
        PIX_WR,
        CLR_WR
    } arb_state_t;

    function automatic logic [17:0] word_addr(input logic [9:0] x, input logic [9:0] y);
        return {x[9:1], y[8:0]};
    endfunction

endpackage

// File: rtl/pixel_wr_fifo.sv
// Synchronous FIFO of pixel-write entries, combinational head read; 1-cycle push-to-visible latency.
// Push is refused when full unless a pop happens in the same cycle; pop on empty is ignored.
module pixel_wr_fifo
    import paint_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  pix_wr_t push_dat,
    input  logic    pop,
    output pix_wr_t pop_dat,
    output logic    full,
    output logic    empty
);
    localparam int AW = $clog2(DEPTH);

    pix_wr_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_frame_arbiter.sv
// Single owner of the async frame SRAM: scan-out reads, queued pixel writes and a clear-screen fill.
// Display read data returns 2 cycles after disp_req; writes wait behind display, queue stalls via wr_ready.
module sram_frame_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int H_RES      = paint_pkg::H_RES,
    parameter int V_RES      = paint_pkg::V_RES
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        disp_req,
    input  logic [17:0] disp_addr,
    output logic [15:0] disp_data,
    output logic        disp_valid,
    input  logic        wr_req,
    input  logic [9:0]  wr_x,
    input  logic [9:0]  wr_y,
    input  logic [7:0]  wr_color,
    output logic        wr_ready,
    input  logic        clr_start,
    input  logic [7:0]  clr_color,
    output logic        clr_busy,
    output logic        clr_done,
    output logic [19:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_out,
    output logic        SRAM_DQ_oe,
    input  logic [15:0] SRAM_DQ_in,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);
    import paint_pkg::*;

    localparam logic [8:0]  XW_LAST = 9'(H_RES / 2 - 1);
    localparam logic [8:0]  Y_LAST  = 9'(V_RES - 1);
    localparam logic [10:0] H_LIM   = 11'(H_RES);
    localparam logic [10:0] V_LIM   = 11'(V_RES);

    arb_state_t state;
    pix_wr_t    wr_ent;
    pix_wr_t    q_head;
    logic       q_full;
    logic       q_empty;
    logic       q_push;
    logic       q_pop;
    logic       in_range;
    logic       fill_grant;
    logic       clr_at_end;
    logic       clr_last;
    logic [8:0] clr_xw;
    logic [8:0] clr_y;
    logic [7:0] clr_c;

    assign wr_ready = !q_full && !clr_busy;
    assign in_range = ({1'b0, wr_x} < H_LIM) && ({1'b0, wr_y} < V_LIM);
    assign wr_ent   = '{x: wr_x, y: wr_y, c: wr_color};
    // Off-screen writes complete the handshake but never enter the queue.
    assign q_push   = wr_req && wr_ready && in_range;

    // clr_last marks the final fill write on the bus; no further fill grants while it retires.
    assign fill_grant = clr_busy && !clr_last && !disp_req;
    assign q_pop      = !disp_req && !fill_grant && !q_empty;
    assign clr_at_end = (clr_xw == XW_LAST) && (clr_y == Y_LAST);

    pixel_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk      (Clk),
        .reset    (Reset),
        .push     (q_push),
        .push_dat (wr_ent),
        .pop      (q_pop),
        .pop_dat  (q_head),
        .full     (q_full),
        .empty    (q_empty)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            SRAM_ADDR   <= '0;
            SRAM_DQ_out <= '0;
            SRAM_DQ_oe  <= 1'b0;
            SRAM_CE_N   <= 1'b0;
            SRAM_OE_N   <= 1'b1;
            SRAM_WE_N   <= 1'b1;
            SRAM_UB_N   <= 1'b1;
            SRAM_LB_N   <= 1'b1;
            disp_data   <= '0;
            disp_valid  <= 1'b0;
            clr_busy    <= 1'b0;
            clr_done    <= 1'b0;
            clr_last    <= 1'b0;
            clr_xw      <= '0;
            clr_y       <= '0;
            clr_c       <= '0;
        end else begin
            SRAM_CE_N  <= 1'b0;
            clr_done   <= 1'b0;
            // The read driven last cycle has settled on the bus by this edge.
            disp_valid <= (state == DISP_RD);
            if (state == DISP_RD) begin
                disp_data <= SRAM_DQ_in;
            end

            if (disp_req) begin
                state      <= DISP_RD;
                SRAM_ADDR  <= {2'b00, disp_addr};
                SRAM_DQ_oe <= 1'b0;
                SRAM_OE_N  <= 1'b0;
                SRAM_WE_N  <= 1'b1;
                SRAM_UB_N  <= 1'b0;
                SRAM_LB_N  <= 1'b0;
            end else if (fill_grant) begin
                state       <= CLR_WR;
                SRAM_ADDR   <= {2'b00, word_addr({clr_xw, 1'b0}, {1'b0, clr_y})};
                SRAM_DQ_out <= {clr_c, clr_c};
                SRAM_DQ_oe  <= 1'b1;
                SRAM_OE_N   <= 1'b1;
                SRAM_WE_N   <= 1'b0;
                SRAM_UB_N   <= 1'b0;
                SRAM_LB_N   <= 1'b0;
            end else if (q_pop) begin
                state       <= PIX_WR;
                SRAM_ADDR   <= {2'b00, word_addr(q_head.x, q_head.y)};
                SRAM_DQ_out <= {q_head.c, q_head.c};
                SRAM_DQ_oe  <= 1'b1;
                SRAM_OE_N   <= 1'b1;
                SRAM_WE_N   <= 1'b0;
                SRAM_UB_N   <= q_head.x[0];
                SRAM_LB_N   <= !q_head.x[0];
            end else begin
                state      <= IDLE;
                SRAM_DQ_oe <= 1'b0;
                SRAM_OE_N  <= 1'b1;
                SRAM_WE_N  <= 1'b1;
                SRAM_UB_N  <= 1'b1;
                SRAM_LB_N  <= 1'b1;
            end

            // Column-major fill: y runs fastest, word column xw advances at the bottom line.
            if (clr_last) begin
                clr_busy <= 1'b0;
                clr_last <= 1'b0;
                clr_done <= 1'b1;
            end else if (fill_grant) begin
                if (clr_at_end) begin
                    clr_last <= 1'b1;
                end else if (clr_y == Y_LAST) begin
                    clr_y  <= '0;
                    clr_xw <= clr_xw + 1'b1;
                end else begin
                    clr_y <= clr_y + 1'b1;
                end
            end else if (clr_start && !clr_busy) begin
                clr_busy <= 1'b1;
                clr_c    <= clr_color;
                clr_xw   <= '0;
                clr_y    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sram_frame_arbiter.sv
// Directed bench for sram_frame_arbiter with a behavioural async SRAM model.
// Reduced screen (64x48) keeps the fill scenarios short.
module tb_sram_frame_arbiter;

    localparam int TB_H = 64;
    localparam int TB_V = 48;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        disp_req;
    logic [17:0] disp_addr;
    logic [15:0] disp_data;
    logic        disp_valid;
    logic        wr_req;
    logic [9:0]  wr_x;
    logic [9:0]  wr_y;
    logic [7:0]  wr_color;
    logic        wr_ready;
    logic        clr_start;
    logic [7:0]  clr_color;
    logic        clr_busy;
    logic        clr_done;
    logic [19:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_out;
    logic        SRAM_DQ_oe;
    logic [15:0] SRAM_DQ_in;
    logic        SRAM_CE_N;
    logic        SRAM_OE_N;
    logic        SRAM_WE_N;
    logic        SRAM_UB_N;
    logic        SRAM_LB_N;

    int checks = 0;
    int failures = 0;

    logic [15:0] mem [0:262143];
    int          we_cnt = 0;
    logic        poke_en = 1'b0;
    logic [17:0] poke_addr = '0;
    logic [15:0] poke_dat = '0;

    always #10 Clk = ~Clk;

    sram_frame_arbiter #(
        .FIFO_DEPTH (4),
        .H_RES      (TB_H),
        .V_RES      (TB_V)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_data   (disp_data),
        .disp_valid  (disp_valid),
        .wr_req      (wr_req),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_color    (wr_color),
        .wr_ready    (wr_ready),
        .clr_start   (clr_start),
        .clr_color   (clr_color),
        .clr_busy    (clr_busy),
        .clr_done    (clr_done),
        .SRAM_ADDR   (SRAM_ADDR),
        .SRAM_DQ_out (SRAM_DQ_out),
        .SRAM_DQ_oe  (SRAM_DQ_oe),
        .SRAM_DQ_in  (SRAM_DQ_in),
        .SRAM_CE_N   (SRAM_CE_N),
        .SRAM_OE_N   (SRAM_OE_N),
        .SRAM_WE_N   (SRAM_WE_N),
        .SRAM_UB_N   (SRAM_UB_N),
        .SRAM_LB_N   (SRAM_LB_N)
    );

    // Async SRAM: reads are combinational, writes land mid-cycle per byte lane.
    assign SRAM_DQ_in = mem[SRAM_ADDR[17:0]];

    always @(negedge Clk) begin
        if (poke_en) begin
            mem[poke_addr] = poke_dat;
        end
        if (!SRAM_CE_N && !SRAM_WE_N) begin
            we_cnt = we_cnt + 1;
            if (!SRAM_UB_N) mem[SRAM_ADDR[17:0]][15:8] = SRAM_DQ_out[15:8];
            if (!SRAM_LB_N) mem[SRAM_ADDR[17:0]][7:0]  = SRAM_DQ_out[7:0];
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic poke(input logic [17:0] a, input logic [15:0] d);
        poke_addr = a;
        poke_dat  = d;
        poke_en   = 1'b1;
        @(negedge Clk);
        #1;
        poke_en = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) tick();
        checks++;
        if ({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_DQ_oe} !== 6'b011110) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=011110",
                     {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_DQ_oe});
        end
        checks++;
        if (SRAM_ADDR !== 20'h0 || SRAM_DQ_out !== 16'h0) begin
            failures++;
            $display("FAIL reset_bus addr=%h dq=%h exp=0/0", SRAM_ADDR, SRAM_DQ_out);
        end
        checks++;
        if ({disp_valid, clr_busy, clr_done} !== 3'b000) begin
            failures++;
            $display("FAIL reset_status got=%b exp=000", {disp_valid, clr_busy, clr_done});
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_wr_ready got=%b exp=1", wr_ready);
        end
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_read_latency();
        poke(18'h00A05, 16'h1234);
        tick();
        disp_req  = 1'b1;
        disp_addr = 18'h00A05;
        tick();
        disp_req = 1'b0;
        checks++;
        if (SRAM_ADDR !== 20'h00A05 || SRAM_OE_N !== 1'b0 || SRAM_WE_N !== 1'b1) begin
            failures++;
            $display("FAIL rd_cycle addr=%h oe_n=%b we_n=%b exp=00a05/0/1", SRAM_ADDR, SRAM_OE_N, SRAM_WE_N);
        end
        checks++;
        if ({SRAM_DQ_oe, SRAM_UB_N, SRAM_LB_N, disp_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL rd_lanes got=%b exp=0000", {SRAM_DQ_oe, SRAM_UB_N, SRAM_LB_N, disp_valid});
        end
        tick();
        checks++;
        if (disp_valid !== 1'b1 || disp_data !== 16'h1234) begin
            failures++;
            $display("FAIL rd_data valid=%b data=%h exp=1/1234", disp_valid, disp_data);
        end
        tick();
        checks++;
        if (disp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rd_pulse valid=%b exp=0", disp_valid);
        end
    endtask

    task automatic test_byte_lanes();
        int n;
        poke(18'h01405, 16'h0000);
        tick();
        wr_req = 1'b1; wr_x = 10'd21; wr_y = 10'd5; wr_color = 8'hE0;
        checks++;
        if (wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL bl_ready got=%b exp=1", wr_ready);
        end
        tick();
        wr_req = 1'b0;
        n = 1;
        while (SRAM_WE_N && n < 8) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 2) begin
            failures++;
            $display("FAIL bl_latency got=%0d exp=2", n);
        end
        checks++;
        if (SRAM_ADDR !== 20'h01405 || SRAM_DQ_out !== 16'hE0E0) begin
            failures++;
            $display("FAIL bl_odd_bus addr=%h dq=%h exp=01405/e0e0", SRAM_ADDR, SRAM_DQ_out);
        end
        checks++;
        if ({SRAM_UB_N, SRAM_LB_N, SRAM_DQ_oe, SRAM_OE_N} !== 4'b1011) begin
            failures++;
            $display("FAIL bl_odd_lanes got=%b exp=1011", {SRAM_UB_N, SRAM_LB_N, SRAM_DQ_oe, SRAM_OE_N});
        end
        tick();
        checks++;
        if (mem[18'h01405] !== 16'h00E0) begin
            failures++;
            $display("FAIL bl_odd_mem got=%h exp=00e0", mem[18'h01405]);
        end
        wr_req = 1'b1; wr_x = 10'd20; wr_y = 10'd5; wr_color = 8'h03;
        tick();
        wr_req = 1'b0;
        n = 1;
        while (SRAM_WE_N && n < 8) begin
            tick();
            n++;
        end
        checks++;
        if ({SRAM_WE_N, SRAM_UB_N, SRAM_LB_N} !== 3'b001 || SRAM_DQ_out !== 16'h0303) begin
            failures++;
            $display("FAIL bl_even_lanes we/ub/lb=%b dq=%h exp=001/0303",
                     {SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, SRAM_DQ_out);
        end
        tick();
        checks++;
        if (mem[18'h01405] !== 16'h03E0) begin
            failures++;
            $display("FAIL bl_even_mem got=%h exp=03e0", mem[18'h01405]);
        end
    endtask

    task automatic test_clipping();
        int we0;
        logic [9:0] xs [4];
        logic [9:0] ys [4];
        xs = '{10'd640, 10'd64, 10'd0, 10'd63};
        ys = '{10'd0,   10'd0,  10'd48, 10'd47};
        we0 = we_cnt;
        for (int i = 0; i < 4; i++) begin
            wr_req = 1'b1; wr_x = xs[i]; wr_y = ys[i]; wr_color = 8'h55;
            checks++;
            if (wr_ready !== 1'b1) begin
                failures++;
                $display("FAIL clip_ready[%0d] got=%b exp=1", i, wr_ready);
            end
            tick();
            wr_req = 1'b0;
            repeat (5) tick();
            checks++;
            if (we_cnt - we0 !== ((i == 3) ? 1 : 0)) begin
                failures++;
                $display("FAIL clip_we[%0d] got=%0d exp=%0d", i, we_cnt - we0, (i == 3) ? 1 : 0);
            end
        end
    endtask

    task automatic test_contention();
        int k = 0;
        int we0;
        int nvalid = 0;
        logic acc;
        logic rq_prev = 1'b0;
        logic [15:0] exp_prev = '0;
        for (int i = 0; i < 4; i++) begin
            poke(18'h02000 + 18'(i), 16'hA000 + 16'(i));
            poke(18'((i << 9) | (40 + i)), 16'h0000);
        end
        tick();
        we0 = we_cnt;
        for (int c = 0; c < 30; c++) begin
            disp_req  = (c % 4 == 0) && (c < 16);
            disp_addr = 18'h02000 + 18'(c / 4);
            acc = 1'b0;
            if (k < 4) begin
                wr_req = 1'b1; wr_x = 10'(2 * k); wr_y = 10'(40 + k); wr_color = 8'(8'h11 * (k + 1));
                acc = wr_ready;
            end else begin
                wr_req = 1'b0;
            end
            tick();
            if (acc) k++;
            checks++;
            if (disp_valid !== rq_prev || (rq_prev && disp_data !== exp_prev)) begin
                failures++;
                $display("FAIL cont_disp c=%0d valid=%b data=%h exp=%b/%h", c, disp_valid, disp_data, rq_prev, exp_prev);
            end
            if (disp_valid) nvalid++;
            rq_prev  = disp_req;
            exp_prev = 16'hA000 + 16'(c / 4);
        end
        disp_req = 1'b0;
        wr_req   = 1'b0;
        checks++;
        if (k !== 4 || nvalid !== 4 || we_cnt - we0 !== 4) begin
            failures++;
            $display("FAIL cont_counts acc=%0d valid=%0d we=%0d exp=4/4/4", k, nvalid, we_cnt - we0);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[18'((i << 9) | (40 + i))] !== {8'(8'h11 * (i + 1)), 8'h00}) begin
                failures++;
                $display("FAIL cont_mem[%0d] got=%h exp=%h", i, mem[18'((i << 9) | (40 + i))],
                         {8'(8'h11 * (i + 1)), 8'h00});
            end
        end
    endtask

    task automatic test_queue_full();
        int k = 0;
        int we0;
        int first_low = -1;
        int nlow = 0;
        logic acc;
        for (int i = 0; i < 5; i++) poke(18'((i << 9) | 44), 16'h0000);
        tick();
        we0 = we_cnt;
        for (int c = 0; c < 20; c++) begin
            disp_req  = (c < 6);
            disp_addr = 18'h02000;
            acc = 1'b0;
            if (k < 5) begin
                wr_req = 1'b1; wr_x = 10'(2 * k + 1); wr_y = 10'd44; wr_color = 8'(8'h20 + k);
                acc = wr_ready;
                if (!wr_ready) begin
                    nlow++;
                    if (first_low < 0) first_low = c;
                end
            end else begin
                wr_req = 1'b0;
            end
            tick();
            if (acc) k++;
        end
        disp_req = 1'b0;
        wr_req   = 1'b0;
        checks++;
        if (first_low !== 4 || nlow !== 3) begin
            failures++;
            $display("FAIL qf_ready first_low=%0d nlow=%0d exp=4/3", first_low, nlow);
        end
        checks++;
        if (k !== 5 || we_cnt - we0 !== 5) begin
            failures++;
            $display("FAIL qf_counts acc=%0d we=%0d exp=5/5", k, we_cnt - we0);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (mem[18'((i << 9) | 44)] !== {8'h00, 8'(8'h20 + i)}) begin
                failures++;
                $display("FAIL qf_mem[%0d] got=%h exp=%h", i, mem[18'((i << 9) | 44)], {8'h00, 8'(8'h20 + i)});
            end
        end
    endtask

    task automatic test_fill();
        int we0;
        int done_cnt = 0;
        int post = 0;
        int bad = 0;
        logic rq_prev = 1'b0;
        poke(18'h00064, 16'hBEEF);
        tick();
        we0 = we_cnt;
        clr_start = 1'b1; clr_color = 8'h1C;
        tick();
        clr_start = 1'b0;
        checks++;
        if (clr_busy !== 1'b1 || wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL fill_start busy=%b wr_ready=%b exp=1/0", clr_busy, wr_ready);
        end
        for (int c = 0; c < 5000 && post < 10; c++) begin
            disp_req  = (c % 4 == 0);
            disp_addr = 18'h00064;
            clr_start = (c == 50);
            clr_color = (c == 50) ? 8'hFF : 8'h1C;
            tick();
            checks++;
            if (disp_valid !== rq_prev || (rq_prev && disp_data !== 16'hBEEF)) begin
                failures++;
                $display("FAIL fill_disp c=%0d valid=%b data=%h exp=%b/beef", c, disp_valid, disp_data, rq_prev);
            end
            if (clr_done) done_cnt++;
            if (done_cnt > 0) post++;
            rq_prev = disp_req;
        end
        disp_req  = 1'b0;
        clr_start = 1'b0;
        tick();
        checks++;
        if (done_cnt !== 1) begin
            failures++;
            $display("FAIL fill_done pulses=%0d exp=1", done_cnt);
        end
        checks++;
        if (we_cnt - we0 !== (TB_H / 2) * TB_V || clr_busy !== 1'b0) begin
            failures++;
            $display("FAIL fill_writes we=%0d busy=%b exp=%0d/0", we_cnt - we0, clr_busy, (TB_H / 2) * TB_V);
        end
        for (int xw = 0; xw < TB_H / 2; xw++) begin
            for (int y = 0; y < TB_V; y++) begin
                if (mem[18'((xw << 9) | y)] !== 16'h1C1C) bad++;
            end
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL fill_mem bad_words=%0d exp=0", bad);
        end
    endtask

    task automatic test_fill_reset();
        int we0;
        int n = 0;
        int dones = 0;
        clr_start = 1'b1; clr_color = 8'h42;
        tick();
        clr_start = 1'b0;
        we0 = we_cnt;
        while (we_cnt - we0 < 1000 && n < 3000) begin
            tick();
            n++;
        end
        checks++;
        if (we_cnt - we0 < 1000) begin
            failures++;
            $display("FAIL fr_progress we=%0d exp>=1000", we_cnt - we0);
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++;
        if (clr_busy !== 1'b0 || SRAM_WE_N !== 1'b1 || wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL fr_reset busy=%b we_n=%b wr_ready=%b exp=0/1/1", clr_busy, SRAM_WE_N, wr_ready);
        end
        we0 = we_cnt;
        for (int c = 0; c < 2000; c++) begin
            tick();
            if (clr_done) dones++;
        end
        checks++;
        if (dones !== 0 || we_cnt - we0 !== 0) begin
            failures++;
            $display("FAIL fr_abort dones=%0d we=%0d exp=0/0", dones, we_cnt - we0);
        end
    endtask

    initial begin
        Reset     = 1'b1;
        disp_req  = 1'b0;
        disp_addr = '0;
        wr_req    = 1'b0;
        wr_x      = '0;
        wr_y      = '0;
        wr_color  = '0;
        clr_start = 1'b0;
        clr_color = '0;
        test_reset();
        test_read_latency();
        test_byte_lanes();
        test_clipping();
        test_contention();
        test_queue_full();
        test_fill();
        test_fill_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
